// File: rtl/div_share_sched.sv
// Round-robin controller sharing one repeated-subtraction divider datapath
// between NREQ requesters; sequences load/subtract strobes and returns results.
module div_share_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dvd_in,
    input  logic [NREQ*WIDTH-1:0] dvs_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      res_quo,
    output logic [WIDTH-1:0]      res_rem,
    output logic                  res_err,
    output logic                  busy,
    output logic [WIDTH-1:0]      dp_dvd,
    output logic [WIDTH-1:0]      dp_dvs,
    output logic                  dp_ld,
    output logic                  dp_sub,
    input  logic                  dp_less,
    input  logic [WIDTH-1:0]      dp_quo,
    input  logic [WIDTH-1:0]      dp_rem
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [IDW-1:0] id_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SUB,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    id_t              id, rr, pick;
    logic             any_req;
    logic [WIDTH-1:0] dvd_arr [NREQ];
    logic [WIDTH-1:0] dvs_arr [NREQ];
    logic [WIDTH-1:0] sel_dvd, sel_dvs;
    logic             res_ld;
    logic [WIDTH-1:0] res_quo_nxt, res_rem_nxt;
    logic             res_err_nxt;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign dvd_arr[g] = dvd_in[g*WIDTH +: WIDTH];
        assign dvs_arr[g] = dvs_in[g*WIDTH +: WIDTH];
    end

    assign sel_dvd = dvd_arr[id];
    assign sel_dvs = dvs_arr[id];
    assign dp_dvd  = (state != S_IDLE) ? sel_dvd : '0;
    assign dp_dvs  = (state != S_IDLE) ? sel_dvs : '0;

    // Scan offsets from the far end so the requester nearest the pointer wins.
    always_comb begin
        id_t cand;
        pick    = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = id_t'((int'(rr) + k) % NREQ);
            if (req[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            id      <= '0;
            rr      <= '0;
            res_quo <= '0;
            res_rem <= '0;
            res_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && any_req)
                id <= pick;
            if (state == S_DONE)
                rr <= (id == id_t'(NREQ - 1)) ? '0 : id + id_t'(1);
            if (res_ld) begin
                res_quo <= res_quo_nxt;
                res_rem <= res_rem_nxt;
                res_err <= res_err_nxt;
            end
        end
    end

    // Results load on entry to DONE so they are already valid alongside ack.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        gnt         = '0;
        ack         = '0;
        busy        = 1'b0;
        dp_ld       = 1'b0;
        dp_sub      = 1'b0;
        res_ld      = 1'b0;
        res_quo_nxt = dp_quo;
        res_rem_nxt = dp_rem;
        res_err_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy    = 1'b1;
                gnt[id] = 1'b1;
                dp_ld   = 1'b1;
                if (sel_dvs == '0) begin
                    res_ld      = 1'b1;
                    res_quo_nxt = '0;
                    res_rem_nxt = sel_dvd;
                    res_err_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end else begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                busy    = 1'b1;
                gnt[id] = 1'b1;
                if (dp_less) begin
                    res_ld    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SUB;
                end
            end
            S_SUB: begin
                busy      = 1'b1;
                gnt[id]   = 1'b1;
                dp_sub    = 1'b1;
                state_nxt = S_CHECK;
            end
            S_DONE: begin
                busy      = 1'b1;
                gnt[id]   = 1'b1;
                ack[id]   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_div_share_sched.sv
// Bench for div_share_sched: behavioural datapath, transaction-level reference
// model compared every cycle, plus directed latency/result literals.
module tb_div_share_sched;

    localparam int W = 16;
    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] dvd_in = '0;
    logic [NREQ*W-1:0] dvs_in = '0;
    logic [NREQ-1:0]   gnt, ack;
    logic [W-1:0]      res_quo, res_rem, dp_dvd, dp_dvs, dp_quo, dp_rem;
    logic              res_err, busy, dp_ld, dp_sub, dp_less;

    div_share_sched #(.WIDTH(W), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .dvd_in(dvd_in), .dvs_in(dvs_in),
        .gnt(gnt), .ack(ack), .res_quo(res_quo), .res_rem(res_rem),
        .res_err(res_err), .busy(busy), .dp_dvd(dp_dvd), .dp_dvs(dp_dvs),
        .dp_ld(dp_ld), .dp_sub(dp_sub), .dp_less(dp_less),
        .dp_quo(dp_quo), .dp_rem(dp_rem)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External repeated-subtraction datapath.
    logic [W-1:0] dpr_dvs;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_rem  <= '0;
            dp_quo  <= '0;
            dpr_dvs <= '0;
        end else if (dp_ld) begin
            dp_rem  <= dp_dvd;
            dpr_dvs <= dp_dvs;
            dp_quo  <= '0;
        end else if (dp_sub) begin
            dp_rem <= dp_rem - dpr_dvs;
            dp_quo <= dp_quo + 1'b1;
        end
    end
    assign dp_less = dp_rem < dpr_dvs;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation is a window of cycles t=1..len after the
    // IDLE cycle that saw the request; len = 2 for /0, else 2*(a/b)+3.
    typedef struct packed {
        int           len;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } op_t;

    function automatic op_t op_calc(input logic [W-1:0] a, input logic [W-1:0] b);
        op_t o;
        if (b == 0) begin
            o.len = 2;
            o.q   = '0;
            o.r   = a;
        end else begin
            o.len = 2 * int'(a / b) + 3;
            o.q   = a / b;
            o.r   = a % b;
        end
        return o;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [W-1:0] dvd_of(input int i);
        return dvd_in[i*W +: W];
    endfunction

    function automatic logic [W-1:0] dvs_of(input int i);
        return dvs_in[i*W +: W];
    endfunction

    bit           m_busy;
    int           m_t, m_id, m_rr;
    op_t          m_op;
    logic [W-1:0] m_quo, m_rem;
    bit           m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_id   <= 0;
            m_rr   <= 0;
            m_op   <= '0;
            m_quo  <= '0;
            m_rem  <= '0;
            m_err  <= 1'b0;
        end else if (!m_busy) begin
            if (rr_pick(req, m_rr) >= 0) begin
                m_busy <= 1'b1;
                m_t    <= 1;
                m_id   <= rr_pick(req, m_rr);
                m_op   <= '0;
            end
        end else if (m_t == m_op.len) begin
            m_busy <= 1'b0;
            m_rr   <= (m_id + 1) % NREQ;
        end else begin
            if (m_t == 1) begin
                m_op <= op_calc(dvd_of(m_id), dvs_of(m_id));
                if (dvs_of(m_id) == 0) begin
                    m_quo <= '0;
                    m_rem <= dvd_of(m_id);
                    m_err <= 1'b1;
                end
            end else if (m_t + 1 == m_op.len) begin
                m_quo <= m_op.q;
                m_rem <= m_op.r;
                m_err <= 1'b0;
            end
            m_t <= m_t + 1;
        end
    end

    logic [NREQ-1:0] e_gnt, e_ack;
    logic            e_ld, e_sub;
    logic [W-1:0]    e_dvd, e_dvs;
    assign e_gnt = m_busy ? (NREQ'(1) << m_id) : '0;
    assign e_ack = (m_busy && m_t == m_op.len) ? (NREQ'(1) << m_id) : '0;
    assign e_ld  = m_busy && m_t == 1;
    assign e_sub = m_busy && m_t >= 3 && (m_t % 2) == 1 && m_t < m_op.len;
    assign e_dvd = m_busy ? dvd_of(m_id) : '0;
    assign e_dvs = m_busy ? dvs_of(m_id) : '0;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("gnt", gnt, e_gnt);
            check("ack", ack, e_ack);
            check("busy", busy, m_busy);
            check("dp_ld", dp_ld, e_ld);
            check("dp_sub", dp_sub, e_sub);
            check("dp_dvd", dp_dvd, e_dvd);
            check("dp_dvs", dp_dvs, e_dvs);
            check("res_quo", res_quo, m_quo);
            check("res_rem", res_rem, m_rem);
            check("res_err", res_err, m_err);
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_dp_ld", dp_ld, 0);
        check("rst_res_quo", res_quo, 0);
        check("rst_res_rem", res_rem, 0);
        check("rst_res_err", res_err, 0);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input int q, input int r, input int e,
                         input int subs, input string tag);
        int n, ns;
        bit seen;
        @(posedge clk);
        #2;
        dvd_in[idx*W +: W] = a;
        dvs_in[idx*W +: W] = b;
        req[idx] = 1'b1;
        n    = cyc;
        ns   = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (dp_sub) ns++;
            if (ack[idx]) begin
                seen = 1'b1;
                check({tag, "_lat"}, cyc - n, lat);
                check({tag, "_quo"}, res_quo, q);
                check({tag, "_rem"}, res_rem, r);
                check({tag, "_err"}, res_err, e);
            end
        end
        check({tag, "_acked"}, seen, 1);
        check({tag, "_subs"}, ns, subs);
        @(posedge clk);
        #2;
        req[idx] = 1'b0;
    endtask

    initial begin
        int n, k;
        bit seen0, seen1;
        int seq[4];

        reset_dut();

        do_op(0, 16'd26, 16'd10, 7, 2, 6, 0, 2, "t1");
        do_op(0, 16'd7,  16'd10, 3, 0, 7, 0, 0, "t2");
        do_op(0, 16'd5,  16'd0,  2, 0, 5, 1, 0, "t3");
        do_op(1, 16'd100, 16'd7, 31, 14, 2, 0, 14, "t3b");

        // Simultaneous requests straight after reset.
        reset_dut();
        @(posedge clk);
        #2;
        dvd_in = {16'd9, 16'd26};
        dvs_in = {16'd3, 16'd10};
        req    = 2'b11;
        n      = cyc;
        seen0  = 1'b0;
        seen1  = 1'b0;
        for (int i = 0; i < 100 && !seen1; i++) begin
            @(negedge clk);
            if (ack[0] && !seen0) begin
                seen0 = 1'b1;
                check("t4_ack0_lat", cyc - n, 7);
                check("t4_ack0_quo", res_quo, 2);
                check("t4_ack0_rem", res_rem, 6);
                @(posedge clk);
                #2;
                req[0] = 1'b0;
            end else if (ack[1]) begin
                seen1 = 1'b1;
                check("t4_ack1_lat", cyc - n, 17);
                check("t4_ack1_quo", res_quo, 3);
                check("t4_ack1_rem", res_rem, 0);
            end
        end
        check("t4_both_acked", {seen0, seen1}, 2'b11);
        @(posedge clk);
        #2;
        req = '0;

        // Both requesters keep asking; service must alternate.
        @(posedge clk);
        #2;
        dvd_in = {16'd6, 16'd7};
        dvs_in = {16'd3, 16'd10};
        req    = 2'b11;
        k      = 0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                seq[k] = ack[1] ? 1 : 0;
                k++;
            end
        end
        check("t5_count", k, 4);
        check("t5_seq0", seq[0], 0);
        check("t5_seq1", seq[1], 1);
        check("t5_seq2", seq[2], 0);
        check("t5_seq3", seq[3], 1);
        @(posedge clk);
        #2;
        req = '0;

        // Reset in the middle of a long division.
        @(posedge clk);
        #2;
        dvd_in[0 +: W] = 16'hffff;
        dvs_in[0 +: W] = 16'd1;
        req[0] = 1'b1;
        seen0  = 1'b0;
        for (int i = 0; i < 20 && !seen0; i++) begin
            @(negedge clk);
            if (dp_sub) seen0 = 1'b1;
        end
        check("t6_sub_seen", seen0, 1);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_ack", ack, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_dp_sub", dp_sub, 0);
        check("t6_rst_dp_ld", dp_ld, 0);
        check("t6_rst_dp_dvd", dp_dvd, 0);
        check("t6_rst_dp_dvs", dp_dvs, 0);
        check("t6_rst_res_quo", res_quo, 0);
        check("t6_rst_res_rem", res_rem, 0);
        check("t6_rst_res_err", res_err, 0);
        req = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t6_no_ack", ack, 0);
        end
        do_op(0, 16'd26, 16'd10, 7, 2, 6, 0, 2, "t6_after");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
